reg_exe_hazard_ctrl: RTL and testbench
======================================

Name: reg_exe_hazard_ctrl

Overview:
- Control unit that sequences the register-to-execute pipeline latch.
- Each cycle it decides whether the instruction in the register stage issues into the execute latch, is held (stall), or is replaced by a bubble.
- Tracks in-flight destination registers in a scoreboard and blocks RAW/WAW hazards.
- Blocks issue while a multi-cycle multiply occupies execute, and flushes the register stage on a taken branch.

Parameters:
- NUM_REGS, 32, number of architectural integer registers; x0 is hardwired zero and never tracked.
- ADDR_WIDTH, 5, register address width (log2 NUM_REGS).
- MUL_LATENCY, 4, execute-stage occupancy of a multiply in cycles; minimum 2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  register stage holds a valid instruction.
- dec_src_a_used  in  1  instruction reads operand A.
- dec_src_a_addr  in  ADDR_WIDTH  operand A register.
- dec_src_b_used  in  1  instruction reads operand B.
- dec_src_b_addr  in  ADDR_WIDTH  operand B register.
- dec_write_enable  in  1  instruction writes an integer register.
- dec_write_addr  in  ADDR_WIDTH  destination register.
- dec_is_mul  in  1  instruction is a multi-cycle multiply.
- exe_branch_taken  in  1  branch in execute resolved taken this cycle.
- wb_write_enable  in  1  writeback commits a register this cycle.
- wb_write_addr  in  ADDR_WIDTH  register committed by writeback.
- issue  out  1  instruction moves into the execute latch at the next edge.
- reg_stall  out  1  hold register stage and all earlier stages.
- exe_bubble  out  1  load the execute latch with zeros (write enable 0, instruction 0).
- exe_hold  out  1  execute latch holds its contents (multiply in progress).
- flush  out  1  invalidate the register stage and younger stages.
- mul_busy  out  1  multiply FSM not in IDLE.

Behaviour:
- Scoreboard: NUM_REGS pending bits, registered. Bit 0 is always 0.
- Register file is write-first, so the effective pending vector is `pending & ~(wb_write_enable ? onehot(wb_write_addr) : 0)`.
- src_hazard = (src_a_used & a≠0 & eff_pending[a]) | (src_b_used & b≠0 & eff_pending[b]).
- waw_hazard = dec_write_enable & waddr≠0 & eff_pending[waddr].
- Multiply FSM states:
  - IDLE: on issue & dec_is_mul, go to MUL and load counter = MUL_LATENCY-1.
  - MUL: counter decrements each cycle; on counter==1 go to IDLE. mul_busy = exe_hold = (state==MUL).
- Combinational decision, in priority order:
  - flush = exe_branch_taken & ~reset. When flush: issue=0, exe_bubble=1, reg_stall=0.
  - Otherwise stall = dec_valid & (src_hazard | waw_hazard | mul_busy). Then reg_stall=stall, issue = dec_valid & ~stall, exe_bubble = ~issue & ~mul_busy.
  - During MUL: exe_bubble=0 and exe_hold=1; the latch keeps the multiply.
- Scoreboard update at the edge:
  - Clear on wb_write_enable at wb_write_addr.
  - Set on issue & dec_write_enable & waddr≠0.
  - Simultaneous set and clear of the same register: set wins.
- Latency: zero-cycle combinational decision; scoreboard and FSM effects are visible the next cycle.
- Reset, including mid-multiply:
  - Next state is pending=0, state IDLE, counter 0.
  - While reset is high: issue=0, reg_stall=0, flush=0, exe_hold=0, mul_busy=0, exe_bubble=1.
- dec_valid=0: issue=0, reg_stall=0, exe_bubble=1 unless MUL.
- A writeback to x0 is ignored.

Decomposition:
- Shared package holds:
  - constant REG_ZERO = 0;
  - ADDR_WIDTH/NUM_REGS constants;
  - enum mul_state_t {IDLE, MUL}.
- One sub-module, reg_scoreboard: pending vector with set/clear ports and two read ports plus WAW port, all with write-first bypass.
- The FSM and decision logic stay in the top module.

Test Plan:
- Reset mid-multiply: issue mul (waddr=7), assert reset on cycle 2 → next cycle mul_busy=0, pending[7]=0, exe_bubble=1 during reset.
- RAW stall: issue add writing x5, then instruction reading x5 with no writeback → reg_stall=1, issue=0, exe_bubble=1 each cycle. wb_write_enable=1, wb_write_addr=5 → issue=1 that same cycle.
- x0 and WAW: instruction writing x0 then reader of x0 → no stall. Instruction writing x9 while pending[9]=1 → stall until writeback of x9.
- Multiply occupancy with MUL_LATENCY=4: issue mul to x3 → mul_busy/exe_hold=1 for exactly 3 cycles; the next valid independent instruction stalls 3 cycles, then issues.
- Branch flush: exe_branch_taken=1 with dec_valid=1 and a hazard present → flush=1, issue=0, reg_stall=0, exe_bubble=1, no pending bit set.
- Same-edge set/clear: wb clears x12 while issuing a new writer of x12 → pending[12]=1 the next cycle; a reader of x12 then stalls.

Source files
------------

// File: rtl/reg_exe_hazard_ctrl_pkg.sv
// reg_exe_hazard_ctrl_pkg: shared constants and types for the register-to-execute hazard controller
// Contents: register-file geometry, the hardwired-zero register index and the multiply FSM state type.
package reg_exe_hazard_ctrl_pkg;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_ZERO   = 0;
    typedef enum logic {IDLE, MUL} mul_state_t;
endpackage

// File: rtl/reg_exe_hazard_ctrl_scoreboard.sv
// reg_scoreboard: pending-write scoreboard with write-first bypass on all read ports
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset (clears all pending bits)
//   i_set_en, i_set_addr    mark a register pending at the next edge (wins over a same-edge clear)
//   i_clr_en, i_clr_addr    writeback commit; clears the bit and is bypassed to the read ports
//   i_rd_a_addr, o_rd_a     operand A pending lookup
//   i_rd_b_addr, o_rd_b     operand B pending lookup
//   i_waw_addr, o_waw       destination pending lookup
module reg_scoreboard
    import reg_exe_hazard_ctrl_pkg::*;
#(
    parameter int P_NUM_REGS   = NUM_REGS,
    parameter int P_ADDR_WIDTH = ADDR_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_set_en,
    input  logic [P_ADDR_WIDTH-1:0] i_set_addr,
    input  logic                    i_clr_en,
    input  logic [P_ADDR_WIDTH-1:0] i_clr_addr,
    input  logic [P_ADDR_WIDTH-1:0] i_rd_a_addr,
    input  logic [P_ADDR_WIDTH-1:0] i_rd_b_addr,
    input  logic [P_ADDR_WIDTH-1:0] i_waw_addr,
    output logic                    o_rd_a,
    output logic                    o_rd_b,
    output logic                    o_waw
);
    logic [P_NUM_REGS-1:0] r_pending;
    logic [P_NUM_REGS-1:0] w_set_mask;
    logic [P_NUM_REGS-1:0] w_clr_mask;
    logic [P_NUM_REGS-1:0] w_eff;
    localparam logic [P_NUM_REGS-1:0] L_KEEP = {{(P_NUM_REGS-1){1'b1}}, 1'b0};

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
        // register file is write-first: a committing writeback no longer counts as pending
        w_eff  = r_pending & ~w_clr_mask;
        o_rd_a = w_eff[i_rd_a_addr];
        o_rd_b = w_eff[i_rd_b_addr];
        o_waw  = w_eff[i_waw_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_pending <= '0;
        else       r_pending <= (w_eff | w_set_mask) & L_KEEP;
    end
endmodule

// File: rtl/reg_exe_hazard_ctrl.sv
// reg_exe_hazard_ctrl: issue/stall/bubble/flush control for the register-to-execute pipeline latch
// Ports:
//   i_clock, i_reset                 clock, synchronous active-high reset
//   i_dec_*                          register-stage instruction: valid, sources, destination, multiply flag
//   i_exe_branch_taken               taken branch in execute; flushes the register stage
//   i_wb_write_enable, i_wb_write_addr  writeback commit (bypassed into hazard checks)
//   o_issue                          instruction enters execute at the next edge
//   o_reg_stall                      hold register stage and earlier
//   o_exe_bubble                     load zeros into the execute latch
//   o_exe_hold                       execute latch keeps its multiply
//   o_flush                          invalidate register stage and younger
//   o_mul_busy                       multiply occupies execute
module reg_exe_hazard_ctrl
    import reg_exe_hazard_ctrl_pkg::*;
#(
    parameter int P_NUM_REGS    = NUM_REGS,
    parameter int P_ADDR_WIDTH  = ADDR_WIDTH,
    parameter int P_MUL_LATENCY = 4
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_dec_valid,
    input  logic                    i_dec_src_a_used,
    input  logic [P_ADDR_WIDTH-1:0] i_dec_src_a_addr,
    input  logic                    i_dec_src_b_used,
    input  logic [P_ADDR_WIDTH-1:0] i_dec_src_b_addr,
    input  logic                    i_dec_write_enable,
    input  logic [P_ADDR_WIDTH-1:0] i_dec_write_addr,
    input  logic                    i_dec_is_mul,
    input  logic                    i_exe_branch_taken,
    input  logic                    i_wb_write_enable,
    input  logic [P_ADDR_WIDTH-1:0] i_wb_write_addr,
    output logic                    o_issue,
    output logic                    o_reg_stall,
    output logic                    o_exe_bubble,
    output logic                    o_exe_hold,
    output logic                    o_flush,
    output logic                    o_mul_busy
);
    localparam int CW = (P_MUL_LATENCY > 2) ? $clog2(P_MUL_LATENCY) : 1;
    localparam logic [P_ADDR_WIDTH-1:0] L_ZERO = P_ADDR_WIDTH'(REG_ZERO);

    mul_state_t      r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            w_pend_a, w_pend_b, w_pend_w;
    logic            w_src_hazard, w_waw_hazard, w_mul_busy, w_flush, w_stall, w_issue;

    reg_scoreboard #(
        .P_NUM_REGS   (P_NUM_REGS),
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_sb (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_set_en    (w_issue & i_dec_write_enable & (i_dec_write_addr != L_ZERO)),
        .i_set_addr  (i_dec_write_addr),
        .i_clr_en    (i_wb_write_enable & (i_wb_write_addr != L_ZERO)),
        .i_clr_addr  (i_wb_write_addr),
        .i_rd_a_addr (i_dec_src_a_addr),
        .i_rd_b_addr (i_dec_src_b_addr),
        .i_waw_addr  (i_dec_write_addr),
        .o_rd_a      (w_pend_a),
        .o_rd_b      (w_pend_b),
        .o_waw       (w_pend_w)
    );

    always_comb begin
        w_src_hazard = (i_dec_src_a_used & (i_dec_src_a_addr != L_ZERO) & w_pend_a)
                     | (i_dec_src_b_used & (i_dec_src_b_addr != L_ZERO) & w_pend_b);
        w_waw_hazard = i_dec_write_enable & (i_dec_write_addr != L_ZERO) & w_pend_w;
        // reset masks the FSM so outputs are quiet even when reset lands mid-multiply
        w_mul_busy   = (r_state == MUL) & ~i_reset;
        w_flush      = i_exe_branch_taken & ~i_reset;
        w_stall      = i_dec_valid & (w_src_hazard | w_waw_hazard | w_mul_busy);
        w_issue      = ~i_reset & ~w_flush & i_dec_valid & ~w_stall;
        o_issue      = w_issue;
        o_reg_stall  = ~i_reset & ~w_flush & w_stall;
        o_exe_bubble = w_flush | (~w_issue & ~w_mul_busy);
        o_exe_hold   = w_mul_busy;
        o_flush      = w_flush;
        o_mul_busy   = w_mul_busy;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            if (w_issue & i_dec_is_mul) begin
                w_state_nxt = MUL;
                w_cnt_nxt   = CW'(P_MUL_LATENCY - 1);
            end
        end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
            w_state_nxt = (r_cnt == CW'(1)) ? IDLE : MUL;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
endmodule

// File: tb/tb_reg_exe_hazard_ctrl.sv
// tb_reg_exe_hazard_ctrl: directed-vector bench for the register-to-execute hazard controller
// Expected outputs are packed as {issue, reg_stall, exe_bubble, exe_hold, flush, mul_busy}.
module tb_reg_exe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid, au, bu, we, mul, br, wbe;
    logic [4:0] a, b, wa, wba;
    logic       issue, reg_stall, exe_bubble, exe_hold, flush, mul_busy;
    logic [5:0] outs;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    reg_exe_hazard_ctrl #(.P_MUL_LATENCY(4)) dut (
        .i_clock            (clk),
        .i_reset            (rst),
        .i_dec_valid        (valid),
        .i_dec_src_a_used   (au),
        .i_dec_src_a_addr   (a),
        .i_dec_src_b_used   (bu),
        .i_dec_src_b_addr   (b),
        .i_dec_write_enable (we),
        .i_dec_write_addr   (wa),
        .i_dec_is_mul       (mul),
        .i_exe_branch_taken (br),
        .i_wb_write_enable  (wbe),
        .i_wb_write_addr    (wba),
        .o_issue            (issue),
        .o_reg_stall        (reg_stall),
        .o_exe_bubble       (exe_bubble),
        .o_exe_hold         (exe_hold),
        .o_flush            (flush),
        .o_mul_busy         (mul_busy)
    );

    assign outs = {issue, reg_stall, exe_bubble, exe_hold, flush, mul_busy};

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // apply one cycle of inputs, compare outputs mid-cycle, then advance past the edge
    task automatic vec(input string tag, input logic v, input logic iau, input logic [4:0] ia,
                       input logic ibu, input logic [4:0] ib, input logic iwe, input logic [4:0] iwa,
                       input logic imul, input logic ibr, input logic iwbe, input logic [4:0] iwba,
                       input logic [5:0] exp);
        valid = v; au = iau; a = ia; bu = ibu; b = ib; we = iwe; wa = iwa;
        mul = imul; br = ibr; wbe = iwbe; wba = iwba;
        #2;
        chk(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        valid = 0; au = 0; bu = 0; we = 0; mul = 0; br = 0; wbe = 0;
        a = 0; b = 0; wa = 0; wba = 0;
        @(posedge clk); #1;
        vec("reset_idle",      1, 0, 0, 0, 0, 1, 5'd4, 0, 1, 0, 0, 6'b001000);
        rst = 1'b0;
        vec("idle_nop",        0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b001000);
        vec("raw_writer_x5",   1, 0, 0, 0, 0, 1, 5'd5, 0, 0, 0, 0, 6'b100000);
        vec("raw_stall_1",     1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 6'b011000);
        vec("raw_stall_2",     1, 0, 0, 1, 5'd5, 0, 0, 0, 0, 0, 0, 6'b011000);
        vec("raw_wb_bypass",   1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 1, 5'd5, 6'b100000);
        vec("x0_writer",       1, 0, 0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 6'b100000);
        vec("x0_reader",       1, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0, 0, 0, 6'b100000);
        vec("waw_first_x9",    1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 6'b100000);
        vec("waw_stall_1",     1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 6'b011000);
        vec("waw_stall_2",     1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 0, 0, 6'b011000);
        vec("waw_wb_release",  1, 0, 0, 0, 0, 1, 5'd9, 0, 0, 1, 5'd9, 6'b100000);
        vec("wb_x9_idle",      0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5'd9, 6'b001000);
        vec("mul_issue_x3",    1, 0, 0, 0, 0, 1, 5'd3, 1, 0, 0, 0, 6'b100000);
        vec("mul_busy_1",      1, 1, 5'd1, 0, 0, 1, 5'd10, 0, 0, 0, 0, 6'b010101);
        vec("mul_busy_2",      1, 1, 5'd1, 0, 0, 1, 5'd10, 0, 0, 0, 0, 6'b010101);
        vec("mul_busy_3",      1, 1, 5'd1, 0, 0, 1, 5'd10, 0, 0, 0, 0, 6'b010101);
        vec("mul_done_issue",  1, 1, 5'd1, 0, 0, 1, 5'd10, 0, 0, 0, 0, 6'b100000);
        vec("wb_x3",           0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5'd3, 6'b001000);
        vec("wb_x10",          0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5'd10, 6'b001000);
        vec("mul2_issue_x4",   1, 0, 0, 0, 0, 1, 5'd4, 1, 0, 0, 0, 6'b100000);
        vec("mul2_novalid",    0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b000101);
        vec("mul2_novalid_2",  0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b000101);
        vec("mul2_novalid_3",  0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b000101);
        vec("mul2_done",       0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5'd4, 6'b001000);
        vec("br_writer_x6",    1, 0, 0, 0, 0, 1, 5'd6, 0, 0, 0, 0, 6'b100000);
        vec("br_flush",        1, 1, 5'd6, 0, 0, 1, 5'd11, 0, 1, 0, 0, 6'b001010);
        vec("br_no_x11_set",   1, 1, 5'd11, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000);
        vec("br_x6_still",     1, 0, 0, 1, 5'd6, 0, 0, 0, 0, 0, 0, 6'b011000);
        vec("wb_x6",           0, 0, 0, 0, 0, 0, 0,    0, 0, 1, 5'd6, 6'b001000);
        vec("sc_writer_x12",   1, 0, 0, 0, 0, 1, 5'd12, 0, 0, 0, 0, 6'b100000);
        vec("sc_set_clr_x12",  1, 0, 0, 0, 0, 1, 5'd12, 0, 0, 1, 5'd12, 6'b100000);
        vec("sc_reader_stall", 1, 1, 5'd12, 0, 0, 0, 0, 0, 0, 0, 0, 6'b011000);
        vec("sc_reader_wb",    1, 1, 5'd12, 0, 0, 0, 0, 0, 0, 1, 5'd12, 6'b100000);
        vec("wb_x0_ignored",   1, 1, 5'd1, 0, 0, 0, 0, 0, 0, 1, 5'd0, 6'b100000);
        vec("rm_mul_x7",       1, 0, 0, 0, 0, 1, 5'd7, 1, 0, 0, 0, 6'b100000);
        vec("rm_busy",         0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b000101);
        rst = 1'b1;
        vec("rm_in_reset",     1, 1, 5'd7, 0, 0, 1, 5'd8, 0, 1, 0, 0, 6'b001000);
        rst = 1'b0;
        vec("rm_x7_cleared",   1, 1, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100000);
        vec("rm_idle_after",   0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 6'b001000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
